reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Architectural register file for the five-stage pipelined core, with an optional per-register pending-write scoreboard. It sits between the decode stage and the ID/EX pipeline register and drives the RD1/RD2 operands that the ID/EX register captures. It is also the write end of that operand path: the writeback stage writes results into it. The scoreboard tracks in-flight destination writes and raises a decode stall on read-after-write hazards that forwarding does not cover.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, number of architectural registers; x0 is hardwired to zero
- MAX_INFLIGHT, 3, maximum outstanding writes per register; counter width is clog2(MAX_INFLIGHT+1)

Ports:
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-low
- A1, A2  in  5  read addresses, rs1 and rs2 from decode
- RD1, RD2  out  XLEN  read data to the ID/EX register
- issue  in  1  decode instruction is accepted into ID/EX this cycle
- RegWriteD  in  1  the issued instruction writes a register
- RdD  in  5  destination of the issued instruction
- killE  in  1  the instruction in EX is squashed this cycle
- RegWriteE  in  1  the squashed EX instruction was a register writer
- RdE  in  5  destination of the squashed EX instruction
- RegWriteW  in  1  writeback enable
- RdW  in  5  writeback destination
- ResultW  in  XLEN  writeback data
- StallD  out  1  RAW hazard; decode must hold
- sb_err  out  1  sticky counter overflow or underflow flag

## Operation
- Write: on the posedge when RegWriteW=1 and RdW≠0, mem[RdW] ← ResultW. Writes to x0 are dropped.
- Read (combinational):
  - RDn = 0 if An=0.
  - Otherwise RDn = ResultW if RegWriteW=1 and RdW=An (write-through bypass).
  - Otherwise RDn = mem[An].
- Scoreboard: one up/down counter per register 1..NREG-1. Per register, each cycle:
  - inc = issue & RegWriteD & (RdD=r)
  - decW = RegWriteW & (RdW=r)
  - decK = killE & RegWriteE & (RdE=r)
  - The counter is updated by the net delta inc − decW − decK, which ranges from −2 to +1.
- Saturation: if the result would exceed MAX_INFLIGHT, the counter holds at MAX_INFLIGHT and sb_err sets. If the result would fall below 0, the counter clamps to 0 and sb_err sets.
- Register 0 is never counted. Inputs with a destination of 0 are ignored.
- StallD = OR over n∈{1,2} of (An≠0 and cnt[An] − decW(An) > 0). The bypass covers the final pending write in the same cycle, so no stall is raised for it.
- StallD does not depend on issue or killE (no combinational loop with the hazard logic).
- sb_err is sticky until reset.

## Timing
- Read latency is 0 cycles. A written value appears in mem on the next cycle and on RDn in the same cycle via the bypass.
- Counter updates take effect at the posedge. StallD reflects them in the following cycle.
- Reset (reset=0 at a posedge) does the following:
  - Clears all mem entries to 0, all counters to 0, and sb_err to 0.
  - A writeback, issue or kill presented in a reset cycle is ignored.
  - A reset mid-flight discards all pending counts.
- Output values during and after reset: RD1=RD2=0 (for a non-bypassed read), StallD=0, sb_err=0.
- Simultaneous events on the same register:
  - issue+writeback: net 0
  - issue+kill: net 0
  - writeback+kill: −2
  - all three: −1

## Configuration
- REGFILE_SCOREBOARD_EN defined: counters, StallD and sb_err are implemented as above.
- REGFILE_SCOREBOARD_EN undefined:
  - No counters are built.
  - StallD is tied to 0 and sb_err is tied to 0.
  - issue, RegWriteD, RdD, killE, RegWriteE and RdE are ignored. Hazards are resolved entirely by forwarding.
  - Register file and bypass behaviour are unchanged.

## Structure
- The shared package riscv_pkg holds XLEN, NREG, REG_ADDR_W=5, and the sb_cnt_t counter typedef.
- Sub-module sb_counter: a saturating up/down counter with inc, decW and decK inputs, a count output and an err output. It is instantiated NREG-1 times in a generate loop. reg_file_sb ORs the err outputs into sb_err.

## Test plan
- Write x5=0xDEADBEEF, then drive reset=0 for one cycle → A1=5 reads RD1=0, StallD=0, sb_err=0.
- RegWriteW=1, RdW=5, ResultW=0xDEADBEEF with A1=5 in the same cycle → RD1=0xDEADBEEF (bypass). The following cycle, with RegWriteW=0 → RD1=0xDEADBEEF.
- Writeback RdW=0, ResultW=0x1234 → A1=0 reads RD1=0. No counter or error change.
- issue with RdD=7 and RegWriteD=1, then A2=7:
  - StallD=1 for the following cycles.
  - In the cycle RegWriteW=1, RdW=7, ResultW=0x55 → StallD=0 and RD2=0x55.
  - Next cycle: cnt[7]=0.
- Four consecutive issues to x3 with no writeback → cnt[3] holds at 3 and sb_err=1. Three writebacks to x3 → cnt[3]=0, StallD=0, sb_err stays 1.
- issue to x9, then killE with RdE=9 → cnt[9]=0 and StallD=0 for A1=9. A further killE to x9 → sb_err=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core constants and helpers for the register file and its pending-write scoreboard.
package riscv_pkg;

  localparam int XLEN            = 32;
  localparam int NREG            = 32;
  localparam int REG_ADDR_W      = 5;
  localparam int SB_MAX_INFLIGHT = 3;
  localparam int SB_CNT_W        = $clog2(SB_MAX_INFLIGHT + 1);

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  function automatic logic addr_hit(input logic en, input logic [REG_ADDR_W-1:0] a,
                                    input logic [REG_ADDR_W-1:0] r);
    return en & (a == r);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down counter of outstanding writes to one register, with a sticky
// overflow/underflow flag. The net step per cycle is inc - decW - decK.
module sb_counter
  import riscv_pkg::*;
#(
  parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             decW,
  input  logic             decK,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  // Two extra bits hold the signed range -2 .. MAX_INFLIGHT+1.
  localparam int SUM_W = CNT_W + 2;
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX_INFLIGHT);

  logic signed [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0]        w_next;
  logic                    w_bad;
  logic [CNT_W-1:0]        r_count;
  logic                    r_err;

  always_comb begin
    w_sum  = SUM_W'(r_count) + SUM_W'(inc) - SUM_W'(decW) - SUM_W'(decK);
    w_next = w_sum[CNT_W-1:0];
    w_bad  = 1'b0;
    if (w_sum[SUM_W-1]) begin
      w_next = '0;
      w_bad  = 1'b1;
    end else if (w_sum > MAX_S) begin
      w_next = CNT_W'(MAX_INFLIGHT);
      w_bad  = 1'b1;
    end else begin
      w_next = w_sum[CNT_W-1:0];
      w_bad  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_err   <= r_err | w_bad;
    end
  end

  assign count = r_count;
  assign err   = r_err;

endmodule

// File: rtl/reg_file_sb.sv
// Architectural register file with write-through bypass and, when REGFILE_SCOREBOARD_EN
// is defined, a per-register pending-write scoreboard driving StallD and sb_err.
module reg_file_sb
  import riscv_pkg::*;
#(
  parameter int XLEN         = riscv_pkg::XLEN,
  parameter int NREG         = riscv_pkg::NREG,
  parameter int MAX_INFLIGHT = riscv_pkg::SB_MAX_INFLIGHT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] A1,
  input  logic [REG_ADDR_W-1:0] A2,
  output logic [XLEN-1:0]       RD1,
  output logic [XLEN-1:0]       RD2,
  input  logic                  issue,
  input  logic                  RegWriteD,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  killE,
  input  logic                  RegWriteE,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [XLEN-1:0]       ResultW,
  output logic                  StallD,
  output logic                  sb_err
);

  logic [XLEN-1:0] r_mem [NREG];
  logic            w_wb1;
  logic            w_wb2;

  assign w_wb1 = addr_hit(RegWriteW, RdW, A1);
  assign w_wb2 = addr_hit(RegWriteW, RdW, A2);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (RegWriteW && (RdW != '0)) begin
      r_mem[RdW] <= ResultW;
    end else begin
      r_mem[0] <= '0;
    end
  end

  // Non-bypassed reads show zero while reset is held, matching the cleared state.
  always_comb begin
    RD1 = '0;
    if (A1 == '0)   RD1 = '0;
    else if (w_wb1) RD1 = ResultW;
    else if (reset) RD1 = r_mem[A1];
    else            RD1 = '0;
  end

  always_comb begin
    RD2 = '0;
    if (A2 == '0)   RD2 = '0;
    else if (w_wb2) RD2 = ResultW;
    else if (reset) RD2 = r_mem[A2];
    else            RD2 = '0;
  end

`ifdef REGFILE_SCOREBOARD_EN
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [CNT_W-1:0] w_cnt [NREG];
  logic [NREG-1:0]  w_err;
  logic             w_pend1;
  logic             w_pend2;

  assign w_cnt[0] = '0;
  assign w_err[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_sb
    logic w_inc;
    logic w_decw;
    logic w_deck;

    assign w_inc  = issue & addr_hit(RegWriteD, RdD, REG_ADDR_W'(r));
    assign w_decw = addr_hit(RegWriteW, RdW, REG_ADDR_W'(r));
    assign w_deck = killE & addr_hit(RegWriteE, RdE, REG_ADDR_W'(r));

    sb_counter #(
      .MAX_INFLIGHT(MAX_INFLIGHT),
      .CNT_W       (CNT_W)
    ) u_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (w_inc),
      .decW (w_decw),
      .decK (w_deck),
      .count(w_cnt[r]),
      .err  (w_err[r])
    );
  end

  // A same-cycle writeback retires one pending write, which the bypass already covers.
  always_comb begin
    w_pend1 = (A1 != '0) && (w_cnt[A1] > CNT_W'(w_wb1));
    w_pend2 = (A2 != '0) && (w_cnt[A2] > CNT_W'(w_wb2));
    StallD  = reset & (w_pend1 | w_pend2);
    sb_err  = reset & (|w_err);
  end
`else
  logic w_unused_sb;

  assign w_unused_sb = &{1'b0, issue, RegWriteD, RdD, killE, RegWriteE, RdE};
  assign StallD      = 1'b0;
  assign sb_err      = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic
// compared every cycle against an array/integer model of the register file and scoreboard.
module tb_reg_file_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int MAXI = 3;
`ifdef REGFILE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [4:0]      A1, A2, RdD, RdE, RdW;
  logic [XLEN-1:0] RD1, RD2, ResultW;
  logic            issue, RegWriteD, killE, RegWriteE, RegWriteW;
  logic            StallD, sb_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  logic [XLEN-1:0] m_mem [NREG];
  int              m_cnt [NREG];
  bit              m_err = 1'b0;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .issue(issue), .RegWriteD(RegWriteD), .RdD(RdD),
    .killE(killE), .RegWriteE(RegWriteE), .RdE(RdE),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .StallD(StallD), .sb_err(sb_err)
  );

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int one(input bit b);
    return b ? 1 : 0;
  endfunction

  function automatic int raw_next(input int r);
    return m_cnt[r] + one(issue && RegWriteD && RdD == 5'(r))
                    - one(RegWriteW && RdW == 5'(r))
                    - one(killE && RegWriteE && RdE == 5'(r));
  endfunction

  function automatic int clamp(input int n);
    if (n < 0) return 0;
    if (n > MAXI) return MAXI;
    return n;
  endfunction

  function automatic bit any_bad();
    for (int r = 1; r < NREG; r++)
      if (raw_next(r) < 0 || raw_next(r) > MAXI) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return '0;
    if (RegWriteW && RdW == a) return ResultW;
    if (!reset) return '0;
    return m_mem[a];
  endfunction

  function automatic bit pending(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    return (m_cnt[a] - one(RegWriteW && RdW == a)) > 0;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        m_mem[i] <= '0;
        m_cnt[i] <= 0;
      end
      m_err <= 1'b0;
    end else begin
      if (RegWriteW && RdW != 5'd0) m_mem[RdW] <= ResultW;
      for (int r = 1; r < NREG; r++) m_cnt[r] <= clamp(raw_next(r));
      m_err <= m_err | any_bad();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("RD1", RD1, exp_rd(A1));
      check("RD2", RD2, exp_rd(A2));
      check("StallD", XLEN'(StallD), XLEN'(SB && reset && (pending(A1) || pending(A2))));
      check("sb_err", XLEN'(sb_err), XLEN'(SB && reset && m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    issue = 1'b0; RegWriteD = 1'b0; RdD = 5'd0;
    killE = 1'b0; RegWriteE = 1'b0; RdE = 5'd0;
    RegWriteW = 1'b0; RdW = 5'd0; ResultW = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0; A1 = 5'd0; A2 = 5'd0;
    tick(); tick();
    reset = 1'b1;
    cmp_en = 1'b1;

    // reset clears a written register
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEADBEEF;
    tick();
    idle(); reset = 1'b0; A1 = 5'd5;
    probe();
    check("rst_rd1", RD1, 32'h0);
    check("rst_stall", XLEN'(StallD), 32'h0);
    check("rst_err", XLEN'(sb_err), 32'h0);
    tick();
    reset = 1'b1;
    probe();
    check("post_rst_rd1", RD1, 32'h0);
    tick();

    // bypass then stored value
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEADBEEF; A1 = 5'd5;
    probe();
    check("bypass_rd1", RD1, 32'hDEADBEEF);
    tick();
    idle();
    probe();
    check("stored_rd1", RD1, 32'hDEADBEEF);
    tick();

    // x0 write is dropped
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h1234; A1 = 5'd0;
    probe();
    check("x0_rd1", RD1, 32'h0);
    tick();
    idle();
    probe();
    check("x0_err", XLEN'(sb_err), 32'h0);
    tick();

    // RAW hazard on x7 cleared by writeback
    issue = 1'b1; RegWriteD = 1'b1; RdD = 5'd7;
    tick();
    idle(); A2 = 5'd7;
    probe();
    check("raw_stall1", XLEN'(StallD), XLEN'(SB));
    tick();
    probe();
    check("raw_stall2", XLEN'(StallD), XLEN'(SB));
    tick();
    RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h55;
    probe();
    check("wb_stall", XLEN'(StallD), 32'h0);
    check("wb_rd2", RD2, 32'h55);
    tick();
    idle();
    probe();
    check("after_wb_stall", XLEN'(StallD), 32'h0);
    check("cnt7", XLEN'(m_cnt[7]), 32'h0);
    tick();

    // saturation on x3
    A2 = 5'd0; A1 = 5'd3;
    issue = 1'b1; RegWriteD = 1'b1; RdD = 5'd3;
    tick(); tick(); tick(); tick();
    idle();
    probe();
    check("cnt3_sat", XLEN'(m_cnt[3]), 32'd3);
    check("sat_stall", XLEN'(StallD), XLEN'(SB));
    check("sat_err", XLEN'(sb_err), XLEN'(SB));
    tick();
    for (int i = 0; i < 3; i++) begin
      RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h100 + 32'(i);
      tick();
    end
    idle();
    probe();
    check("cnt3_drain", XLEN'(m_cnt[3]), 32'd0);
    check("drain_stall", XLEN'(StallD), 32'h0);
    check("drain_err", XLEN'(sb_err), XLEN'(SB));
    check("drain_rd1", RD1, 32'h102);
    tick();

    // kill of x9, then underflow
    reset = 1'b0;
    tick();
    reset = 1'b1; A1 = 5'd9;
    issue = 1'b1; RegWriteD = 1'b1; RdD = 5'd9;
    tick();
    idle(); killE = 1'b1; RegWriteE = 1'b1; RdE = 5'd9;
    probe();
    check("kill_cycle_stall", XLEN'(StallD), XLEN'(SB));
    tick();
    idle();
    probe();
    check("kill_stall", XLEN'(StallD), 32'h0);
    check("kill_err", XLEN'(sb_err), 32'h0);
    check("cnt9", XLEN'(m_cnt[9]), 32'h0);
    tick();
    killE = 1'b1; RegWriteE = 1'b1; RdE = 5'd9;
    tick();
    idle();
    probe();
    check("underflow_err", XLEN'(sb_err), XLEN'(SB));
    tick();

    // randomized traffic on a narrow address range to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(63, 0) != 0);
      A1        = 5'($urandom_range(7, 0));
      A2        = 5'($urandom_range(7, 0));
      issue     = 1'($urandom_range(1, 0));
      RegWriteD = 1'($urandom_range(1, 0));
      RdD       = 5'($urandom_range(7, 0));
      killE     = ($urandom_range(3, 0) == 0);
      RegWriteE = 1'($urandom_range(1, 0));
      RdE       = 5'($urandom_range(7, 0));
      RegWriteW = 1'($urandom_range(1, 0));
      RdW       = 5'($urandom_range(7, 0));
      ResultW   = $urandom;
      tick();
    end
    idle(); reset = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
